mem_responder: RTL

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_pkg.sv | 27 ++
 rtl/mem_responder_req_fifo.sv | 69 ++++++
 rtl/mem_responder.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the memory responder: read destination kinds and
// the request-queue entry layout.
// Entry fields are sized to the widest supported configuration; modules
// zero-extend into them and slice back out to their own parameter widths,
// so MAIN_ADDR_WIDTH must not exceed ADDR_MAX and WORD_WIDTH must not
// exceed DATA_MAX.
package mem_pkg;

  localparam int unsigned ADDR_MAX = 32;
  localparam int unsigned DATA_MAX = 64;

  typedef enum logic [1:0] {
    KIND_RELOAD   = 2'd0,
    KIND_CONVEYOR = 2'd1,
    KIND_DSTACK   = 2'd2,
    KIND_STREAM   = 2'd3
  } kind_e;

  typedef struct packed {
    logic                is_write;
    logic [ADDR_MAX-1:0] addr;
    logic [DATA_MAX-1:0] data;
    kind_e               kind;
    logic [1:0]          choice;
  } entry_t;

endpackage

// File: rtl/mem_responder_req_fifo.sv
// req_fifo: request queue accepting up to two entries and releasing one per
// cycle.
// Ports:
//   clk, reset            clock, synchronous active-low reset
//   push_first/entry_first   entry placed first in queue order
//   push_second/entry_second entry placed after entry_first
//   pop                   dequeue the head (ignored when empty)
//   head                  current head entry
//   empty                 queue holds no entries
//   room2_next            after this edge, at least two entries will be free
module req_fifo
  import mem_pkg::*;
#(
  parameter int unsigned QUEUE_DEPTH = 4
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   push_first,
  input  entry_t entry_first,
  input  logic   push_second,
  input  entry_t entry_second,
  input  logic   pop,
  output entry_t head,
  output logic   empty,
  output logic   room2_next
);

  localparam int unsigned PTR_W = $clog2(QUEUE_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  entry_t           mem [QUEUE_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] second_slot;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_next;
  logic             do_pop;

  assign empty  = (count == '0);
  assign do_pop = pop && !empty;
  assign head   = mem[rd_ptr];

  // The second entry lands directly behind the first only when the first is
  // actually pushed; otherwise it takes the current write slot.
  assign second_slot = wr_ptr + PTR_W'(push_first);

  always_comb begin
    count_next = count + CNT_W'(push_first) + CNT_W'(push_second) - CNT_W'(do_pop);
    room2_next = (count_next <= CNT_W'(QUEUE_DEPTH - 2));
  end

  always_ff @(posedge clk) begin
    if (push_first)  mem[wr_ptr]      <= entry_first;
    if (push_second) mem[second_slot] <= entry_second;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + PTR_W'(push_first) + PTR_W'(push_second);
      if (do_pop) rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count_next;
    end
  end

endmodule

// File: rtl/mem_responder.sv
// mem_responder: queues write/read requests, issues one per cycle to a
// synchronous single-port RAM and returns tagged read responses.
// Ports:
//   clk, reset                         clock, synchronous active-low reset
//   write_out/write_address/write_value  write request
//   read_out/read_address/read_kind/read_choice  read request and tags
//   req_ready                          both requests this cycle are taken
//   ram_en/ram_we/ram_addr/ram_wdata   RAM access (registered)
//   ram_rdata                          RAM read data, one cycle after strobe
//   resp_valid/resp_kind/resp_choice/resp_addr/resp_data  read response
module mem_responder
  import mem_pkg::*;
#(
  parameter int unsigned MAIN_ADDR_WIDTH = 1,
  parameter int unsigned WORD_WIDTH      = 32,
  parameter int unsigned QUEUE_DEPTH     = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       write_out,
  input  logic [MAIN_ADDR_WIDTH-1:0] write_address,
  input  logic [WORD_WIDTH-1:0]      write_value,
  input  logic                       read_out,
  input  logic [MAIN_ADDR_WIDTH-1:0] read_address,
  input  logic [1:0]                 read_kind,
  input  logic [1:0]                 read_choice,
  output logic                       req_ready,
  output logic                       ram_en,
  output logic                       ram_we,
  output logic [MAIN_ADDR_WIDTH-1:0] ram_addr,
  output logic [WORD_WIDTH-1:0]      ram_wdata,
  input  logic [WORD_WIDTH-1:0]      ram_rdata,
  output logic                       resp_valid,
  output logic [1:0]                 resp_kind,
  output logic [1:0]                 resp_choice,
  output logic [MAIN_ADDR_WIDTH-1:0] resp_addr,
  output logic [WORD_WIDTH-1:0]      resp_data
);

  logic   ready_q;
  logic   push_write;
  logic   push_read;
  logic   empty;
  logic   room2_next;
  entry_t w_entry;
  entry_t r_entry;
  entry_t head;
  logic   unused_hi;

  // Issue-stage tags travel alongside the RAM strobe; the second stage lines
  // up with ram_rdata becoming valid.
  logic                       iss_read;
  kind_e                      iss_kind;
  logic [1:0]                 iss_choice;
  logic                       tag_valid;
  kind_e                      tag_kind;
  logic [1:0]                 tag_choice;
  logic [MAIN_ADDR_WIDTH-1:0] tag_addr;

  assign req_ready  = ready_q;
  assign push_write = ready_q && write_out;
  assign push_read  = ready_q && read_out;

  // Upper entry bits are always written as zero for this configuration.
  assign unused_hi = (|(head.addr >> MAIN_ADDR_WIDTH)) | (|(head.data >> WORD_WIDTH));

  always_comb begin
    w_entry                             = '0;
    w_entry.is_write                    = 1'b1;
    w_entry.addr[MAIN_ADDR_WIDTH-1:0]   = write_address;
    w_entry.data[WORD_WIDTH-1:0]        = write_value;
    w_entry.kind                        = KIND_RELOAD;
    r_entry                             = '0;
    r_entry.is_write                    = 1'b0;
    r_entry.addr[MAIN_ADDR_WIDTH-1:0]   = read_address;
    r_entry.kind                        = kind_e'(read_kind);
    r_entry.choice                      = read_choice;
  end

  // Write goes first so a same-cycle read of that address sees the new data.
  req_fifo #(
    .QUEUE_DEPTH(QUEUE_DEPTH)
  ) u_fifo (
    .clk          (clk),
    .reset        (reset),
    .push_first   (push_write),
    .entry_first  (w_entry),
    .push_second  (push_read),
    .entry_second (r_entry),
    .pop          (!empty),
    .head         (head),
    .empty        (empty),
    .room2_next   (room2_next)
  );

  // Registered ready stays low through reset and rises on the first edge
  // after release, when the queue is known empty.
  always_ff @(posedge clk) begin
    if (!reset) ready_q <= 1'b0;
    else        ready_q <= room2_next;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ram_en     <= 1'b0;
      ram_we     <= 1'b0;
      ram_addr   <= '0;
      ram_wdata  <= '0;
      iss_read   <= 1'b0;
      iss_kind   <= KIND_RELOAD;
      iss_choice <= '0;
    end else if (!empty) begin
      ram_en     <= 1'b1;
      ram_we     <= head.is_write;
      ram_addr   <= head.addr[MAIN_ADDR_WIDTH-1:0];
      ram_wdata  <= head.data[WORD_WIDTH-1:0];
      iss_read   <= !head.is_write;
      iss_kind   <= head.kind;
      iss_choice <= head.choice;
    end else begin
      ram_en   <= 1'b0;
      ram_we   <= 1'b0;
      iss_read <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      tag_valid  <= 1'b0;
      tag_kind   <= KIND_RELOAD;
      tag_choice <= '0;
      tag_addr   <= '0;
    end else begin
      tag_valid  <= iss_read;
      tag_kind   <= iss_kind;
      tag_choice <= iss_choice;
      tag_addr   <= ram_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      resp_valid  <= 1'b0;
      resp_kind   <= '0;
      resp_choice <= '0;
      resp_addr   <= '0;
      resp_data   <= '0;
    end else begin
      resp_valid <= tag_valid;
      if (tag_valid) begin
        resp_kind   <= tag_kind;
        resp_choice <= tag_choice;
        resp_addr   <= tag_addr;
        resp_data   <= ram_rdata;
      end
    end
  end

endmodule
